// File: rtl/tjmonopix2_cmd_arbiter.sv
// Command-link scheduler for TJ-Monopix2: arbitrates trigger and requester frames onto one serial line.
// Optional frame statistics outputs are enabled by defining TJMONOPIX2_CMD_ARB_STATS_EN.
module tjmonopix2_cmd_arbiter #(
    parameter int          N_REQ       = 3,
    parameter logic [15:0] SYNC_WORD   = 16'h817E,
    parameter int          SYNC_PERIOD = 32
) (
    input  logic                 CLK,
    input  logic                 RESETB,
    input  logic                 ENABLE,
    input  logic [N_REQ-1:0]     REQ_VALID,
    input  logic [16*N_REQ-1:0]  REQ_DATA,
    input  logic [N_REQ-1:0]     REQ_LAST,
    output logic [N_REQ-1:0]     REQ_READY,
    input  logic                 TRIG_VALID,
    input  logic [15:0]          TRIG_DATA,
    output logic                 TRIG_READY,
    output logic                 CMD_OUT,
    output logic                 BUSY
`ifdef TJMONOPIX2_CMD_ARB_STATS_EN
    ,
    output logic [31:0]          TX_FRAME_CNT,
    output logic [31:0]          SYNC_CNT
`endif
);

    localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int SW = $clog2(SYNC_PERIOD + 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    logic [1:0]         state;
    logic [3:0]         bit_cnt;
    logic [15:0]        shift_reg;
    logic               data_shifting;
    logic [IW-1:0]      rr_ptr;
    logic [IW-1:0]      lock_id;
    logic               lock_valid;
    logic [SW-1:0]      since_sync;

    logic               load_slot;
    logic               loading;
    logic               rr_found;
    logic [IW-1:0]      rr_sel;
    logic [2*N_REQ-1:0] valid_rot;
    logic [IW:0]        rr_sum;
    logic               sel_trig;
    logic               sel_req;
    logic [IW-1:0]      sel_id;
    logic [15:0]        frame;
    logic [IW-1:0]      rr_next;

    assign load_slot = (state == ST_RUN) && (bit_cnt == 4'd15);
    assign loading   = load_slot && ENABLE && RESETB;

    // Rotate the valid vector so that the lowest set bit is the nearest requester at or above rr_ptr.
    always_comb begin
        rr_found  = 1'b0;
        rr_sel    = '0;
        rr_sum    = '0;
        valid_rot = {REQ_VALID, REQ_VALID} >> rr_ptr;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (valid_rot[k]) begin
                rr_found = 1'b1;
                rr_sum   = {1'b0, rr_ptr} + (IW+1)'(k);
                if (rr_sum >= (IW+1)'(N_REQ)) begin
                    rr_sum = rr_sum - (IW+1)'(N_REQ);
                end
                rr_sel = rr_sum[IW-1:0];
            end
        end
    end

    always_comb begin
        sel_trig  = 1'b0;
        sel_req   = 1'b0;
        sel_id    = rr_sel;
        REQ_READY = '0;
        if (loading) begin
            if (TRIG_VALID) begin
                sel_trig = 1'b1;
            end else if (since_sync == SW'(SYNC_PERIOD)) begin
                sel_req = 1'b0;
            end else if (lock_valid) begin
                sel_id  = lock_id;
                sel_req = REQ_VALID[lock_id];
            end else begin
                sel_req = rr_found;
            end
        end
        frame = SYNC_WORD;
        if (sel_trig) begin
            frame = TRIG_DATA;
        end else if (sel_req) begin
            frame = REQ_DATA[16*sel_id +: 16];
        end
        if (sel_req) begin
            REQ_READY[sel_id] = 1'b1;
        end
    end

    assign TRIG_READY = sel_trig;
    assign rr_next    = (sel_id == IW'(N_REQ - 1)) ? '0 : sel_id + IW'(1);
    assign BUSY       = lock_valid | data_shifting;

    always_ff @(posedge CLK) begin
        if (!RESETB) begin
            state         <= ST_IDLE;
            bit_cnt       <= 4'd0;
            shift_reg     <= 16'd0;
            CMD_OUT       <= 1'b0;
            data_shifting <= 1'b0;
            rr_ptr        <= '0;
            lock_id       <= '0;
            lock_valid    <= 1'b0;
            since_sync    <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    CMD_OUT       <= 1'b0;
                    data_shifting <= 1'b0;
                    // Starting at 15 makes the first RUN cycle a load slot.
                    bit_cnt       <= ENABLE ? 4'd15 : 4'd0;
                    if (ENABLE) begin
                        state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    bit_cnt <= bit_cnt + 4'd1;
                    if (load_slot) begin
                        if (ENABLE) begin
                            CMD_OUT       <= frame[15];
                            shift_reg     <= {frame[14:0], 1'b0};
                            data_shifting <= sel_trig | sel_req;
                            if (sel_trig || sel_req) begin
                                if (since_sync != SW'(SYNC_PERIOD)) begin
                                    since_sync <= since_sync + SW'(1);
                                end
                            end else begin
                                since_sync <= '0;
                            end
                            if (sel_req) begin
                                rr_ptr     <= rr_next;
                                lock_id    <= sel_id;
                                lock_valid <= !REQ_LAST[sel_id];
                            end
                        end else begin
                            state         <= ST_DRAIN;
                            bit_cnt       <= 4'd0;
                            CMD_OUT       <= 1'b0;
                            data_shifting <= 1'b0;
                        end
                    end else begin
                        CMD_OUT   <= shift_reg[15];
                        shift_reg <= {shift_reg[14:0], 1'b0};
                    end
                end
                ST_DRAIN: begin
                    state      <= ST_IDLE;
                    CMD_OUT    <= 1'b0;
                    since_sync <= '0;
                end
                default: begin
                    state   <= ST_IDLE;
                    CMD_OUT <= 1'b0;
                end
            endcase
        end
    end

`ifdef TJMONOPIX2_CMD_ARB_STATS_EN
    always_ff @(posedge CLK) begin
        if (!RESETB) begin
            TX_FRAME_CNT <= 32'd0;
            SYNC_CNT     <= 32'd0;
        end else if (loading) begin
            if (sel_trig || sel_req) begin
                TX_FRAME_CNT <= TX_FRAME_CNT + 32'd1;
            end else begin
                SYNC_CNT <= SYNC_CNT + 32'd1;
            end
        end
    end
`endif

endmodule
